ondemand_responder: RTL and testbench



---
 rtl/ondemand_responder.sv | 77 +++++++
 tb/tb_ondemand_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ondemand_responder.sv
// ondemand_responder: responder end of the byte channel, buffers requests and returns ~x in order; ONDEMAND_RSP_PARITY_EN adds rsp_parity
module ondemand_responder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
`ifdef ONDEMAND_RSP_PARITY_EN
  output logic                     rsp_parity,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);
`ifdef ONDEMAND_RSP_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [7:0] stall_q, stall_d;
  logic req_ready_q, rsp_valid_q, ovf_q;
  logic push, pop, stall;
  logic [EW-1:0] entry;
`ifdef ONDEMAND_RSP_PARITY_EN
  assign entry = {^(~req_data), ~req_data};
  assign rsp_parity = mem_q[rd_ptr_q][WIDTH];
`else
  assign entry = ~req_data;
`endif
  assign req_ready = req_ready_q && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = mem_q[rd_ptr_q][WIDTH-1:0];
  assign level = level_q;
  assign overflow_err = ovf_q;
  // handshakes, pointer/level next state and the saturating stall count
  always_comb begin
    push = req_valid && req_ready;
    pop = rsp_valid_q && rsp_ready;
    stall = req_valid && !req_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
    stall_d = !stall ? 8'd0 : (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
  end
  // storage and registered flags; ready/valid come from next-state level so nothing is combinational req->rsp
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      stall_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      stall_q <= stall_d;
      req_ready_q <= level_d != FULL;
      rsp_valid_q <= level_d != '0;
      if (stall && stall_q == 8'hFF) ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ondemand_responder.sv
// tb_ondemand_responder: queue-model checker plus directed scenarios for ondemand_responder
module tb_ondemand_responder;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic rsp_ready = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic req_ready, rsp_valid, overflow_err;
  logic [7:0] rsp_data;
  logic [2:0] level;
`ifdef ONDEMAND_RSP_PARITY_EN
  logic rsp_parity;
`endif
  int checks = 0;
  int passed = 0;
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit m_ready = 1'b1;
  int m_stall = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  ondemand_responder #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
`ifdef ONDEMAND_RSP_PARITY_EN
    .rsp_parity(rsp_parity),
`endif
    .level(level),
    .overflow_err(overflow_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // per-cycle compare against the queue model, then advance the model with the inputs the next edge will sample
  initial forever begin
    bit rdy;
    @(negedge clk);
    check("m_req_ready", {31'd0, req_ready}, {31'd0, m_ready && !rst});
    check("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, mq.size() != 0});
    check("m_level", {29'd0, level}, mq.size());
    check("m_overflow", {31'd0, overflow_err}, {31'd0, m_ovf});
    if (mq.size() != 0) begin
      check("m_rsp_data", {24'd0, rsp_data}, {24'd0, mq[0]});
`ifdef ONDEMAND_RSP_PARITY_EN
      check("m_rsp_parity", {31'd0, rsp_parity}, {31'd0, ^mq[0]});
`endif
    end
    if (!rst && rsp_valid && rsp_ready) got.push_back(rsp_data);
    if (rst) begin
      mq.delete();
      m_ready = 1'b1;
      m_stall = 0;
      m_ovf = 1'b0;
    end else begin
      rdy = m_ready;
      if (req_valid && !rdy) begin
        if (m_stall == 255) m_ovf = 1'b1;
        else m_stall++;
      end else m_stall = 0;
      if (mq.size() != 0 && rsp_ready) void'(mq.pop_front());
      if (req_valid && rdy) mq.push_back(~req_data);
      m_ready = mq.size() != DEPTH;
    end
  end

  initial begin
    logic [7:0] burst_in [4] = '{8'h00, 8'h01, 8'hFF, 8'h80};
    logic [7:0] burst_exp [4] = '{8'hFF, 8'hFE, 8'h00, 8'h7F};
    logic [7:0] full_exp [5] = '{8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF};
    logic [7:0] stream_in [10];
    // reset
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_level", {29'd0, level}, 32'd0);
    check("post_rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("post_rst_overflow", {31'd0, overflow_err}, 32'd0);
    // single request A5
    req_valid = 1'b1; req_data = 8'hA5; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("single_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_data", {24'd0, rsp_data}, 32'h5A);
    tick();
    check("single_level_after", {29'd0, level}, 32'd0);
    check("single_valid_after", {31'd0, rsp_valid}, 32'd0);
    // burst into a blocked FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_data = burst_in[i];
      tick();
    end
    req_valid = 1'b0;
    check("burst_level", {29'd0, level}, 32'd4);
    check("burst_ready_full", {31'd0, req_ready}, 32'd0);
    got.delete();
    rsp_ready = 1'b1;
    tick();
    check("burst_ready_after_pop", {31'd0, req_ready}, 32'd1);
    tick(); tick(); tick(); tick();
    check("burst_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("burst_out%0d", i), {24'd0, (i < got.size()) ? got[i] : 8'hxx}, {24'd0, burst_exp[i]});
    // full with simultaneous req_valid and rsp_ready
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_data = 8'h10 * (i + 1);
      tick();
    end
    got.delete();
    req_valid = 1'b1; req_data = 8'h50; rsp_ready = 1'b1;
    tick();
    check("full_pop_level", {29'd0, level}, 32'd3);
    check("full_pop_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("full_resume_level", {29'd0, level}, 32'd3);
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("full_count", got.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("full_out%0d", i), {24'd0, (i < got.size()) ? got[i] : 8'hxx}, {24'd0, full_exp[i]});
    // streaming 10 bytes
    got.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stream_in[i] = 8'(i * 37 + 3);
      req_valid = 1'b1; req_data = stream_in[i];
      tick();
      if (i > 0) check($sformatf("stream_level%0d", i), {29'd0, level}, 32'd1);
    end
    req_valid = 1'b0;
    tick(); tick();
    check("stream_count", got.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("stream_out%0d", i), {24'd0, (i < got.size()) ? got[i] : 8'hxx}, {24'd0, ~stream_in[i]});
    // overflow after a long stall
    rsp_ready = 1'b0; req_valid = 1'b1; req_data = 8'h3C;
    for (int i = 0; i < 4 + 255; i++) tick();
    check("ovf_at_255", {31'd0, overflow_err}, 32'd0);
    tick();
    check("ovf_at_256", {31'd0, overflow_err}, 32'd1);
    tick();
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    check("ovf_drained", {29'd0, level}, 32'd0);
    // reset mid-operation
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_data = 8'h11 + 8'(i);
      tick();
    end
    req_valid = 1'b0;
    check("pre_rst_level", {29'd0, level}, 32'd3);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_data", {24'd0, rsp_data}, 32'h00);
    check("mid_rst_overflow", {31'd0, overflow_err}, 32'd0);
    rst = 1'b0;
    tick();
    req_valid = 1'b1; req_data = 8'h03;
    tick();
    req_valid = 1'b0;
    check("after_rst_data", {24'd0, rsp_data}, 32'hFC);
`ifdef ONDEMAND_RSP_PARITY_EN
    check("after_rst_parity", {31'd0, rsp_parity}, 32'd0);
`endif
    rsp_ready = 1'b1;
    tick(); tick();
    check("final_level", {29'd0, level}, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
